arrow_launch_scheduler: RTL and testbench

Sequences arrow launches for the play field from a song step pattern. On each musical beat (a fixed number of frame ticks) it fetches one step, a lane mask, from an external synchronous step ROM. For every set lane it allocates a free arrow slot of the movement datapath and pulses that slot's launch. It arbitrates the ARROW_COUNT slots, drops notes when no slot is free, and reports song completion.

---
 rtl/arrow_launch_scheduler.sv | 157 +++++++++++++++
 tb/tb_arrow_launch_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arrow_launch_scheduler.sv
// arrow_launch_scheduler: per-beat step fetch and arrow slot allocation.
// Each beat fetches one lane mask from a synchronous step ROM. Every set lane
// gets the lowest free arrow slot, or is counted as a drop when no slot is free.
// Optional build macro: LOOP_SONG_EN (wrap to step 0 instead of ending in DONE).
module arrow_launch_scheduler #(
  parameter int unsigned FRAMES_PER_BEAT = 15,
  parameter int unsigned SONG_LEN        = 64,
  parameter int unsigned ADDR_W          = 6,
  parameter int unsigned LANES           = 4,
  parameter int unsigned ARROW_COUNT     = 4,
  localparam int unsigned LANE_W         = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic                          frame_i,
  output logic [ADDR_W-1:0]             step_addr_o,
  input  logic [LANES-1:0]              step_data_i,
  input  logic [ARROW_COUNT-1:0]        slot_done_i,
  output logic [ARROW_COUNT-1:0]        launch_o,
  output logic [ARROW_COUNT*LANE_W-1:0] slot_lane_o,
  output logic [ARROW_COUNT-1:0]        slot_busy_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [7:0]                    drop_count_o
);

  localparam int unsigned CNT_W  = (FRAMES_PER_BEAT > 1) ? $clog2(FRAMES_PER_BEAT) : 1;
  localparam int unsigned SLOT_W = (ARROW_COUNT > 1) ? $clog2(ARROW_COUNT) : 1;
  localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(FRAMES_PER_BEAT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BEAT,
    S_FETCH,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   frame_cnt_q;
  logic               beat_pending_q;
  logic [LANES-1:0]   mask_q;

  logic               lane_found;
  logic [LANE_W-1:0]  lane_idx;
  logic               slot_found;
  logic [SLOT_W-1:0]  slot_idx;
  logic               timer_run;

  // Lowest set lane of the pending mask.
  always_comb begin
    lane_found = 1'b0;
    lane_idx   = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        lane_found = 1'b1;
        lane_idx   = LANE_W'(i);
      end
    end
  end

  // Lowest free slot, judged on registered occupancy so a same-cycle release is not yet visible.
  always_comb begin
    slot_found = 1'b0;
    slot_idx   = '0;
    for (int i = int'(ARROW_COUNT) - 1; i >= 0; i--) begin
      if (!slot_busy_o[i]) begin
        slot_found = 1'b1;
        slot_idx   = SLOT_W'(i);
      end
    end
  end

  assign timer_run = (state_q == S_WAIT_BEAT) || (state_q == S_FETCH) || (state_q == S_ISSUE);

  // Sequencer FSM, beat timer, slot table and drop counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      frame_cnt_q    <= '0;
      beat_pending_q <= 1'b0;
      mask_q         <= '0;
      step_addr_o    <= '0;
      launch_o       <= '0;
      slot_lane_o    <= '0;
      slot_busy_o    <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      drop_count_o   <= '0;
    end else begin
      launch_o    <= '0;
      slot_busy_o <= slot_busy_o & ~slot_done_i;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q        <= S_WAIT_BEAT;
            step_addr_o    <= '0;
            frame_cnt_q    <= '0;
            beat_pending_q <= 1'b0;
            drop_count_o   <= '0;
            busy_o         <= 1'b1;
            done_o         <= 1'b0;
          end
        end
        S_WAIT_BEAT: begin
          if (beat_pending_q) begin
            beat_pending_q <= 1'b0;
            state_q        <= S_FETCH;
          end
        end
        S_FETCH: begin
          mask_q  <= step_data_i;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (lane_found) begin
            mask_q[lane_idx] <= 1'b0;
            if (slot_found) begin
              launch_o[slot_idx]                          <= 1'b1;
              slot_busy_o[slot_idx]                       <= 1'b1;
              slot_lane_o[slot_idx*LANE_W +: LANE_W]      <= lane_idx;
            end else if (drop_count_o != 8'hFF) begin
              drop_count_o <= drop_count_o + 8'd1;
            end
          end else if (step_addr_o == LAST_ADDR) begin
`ifdef LOOP_SONG_EN
            step_addr_o <= '0;
            state_q     <= S_WAIT_BEAT;
`else
            state_q <= S_DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
`endif
          end else begin
            step_addr_o <= step_addr_o + ADDR_W'(1);
            state_q     <= S_WAIT_BEAT;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Beat timer; a wrap here wins over a same-cycle consume above.
      if (timer_run && frame_i) begin
        if (frame_cnt_q == BEAT_LAST) begin
          frame_cnt_q    <= '0;
          beat_pending_q <= 1'b1;
        end else begin
          frame_cnt_q <= frame_cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_arrow_launch_scheduler.sv
// Directed bench for arrow_launch_scheduler with a behavioural synchronous step ROM.
module tb_arrow_launch_scheduler;

  localparam int unsigned FPB    = 2;
  localparam int unsigned SLEN   = 80;
  localparam int unsigned AW     = 7;
  localparam int unsigned NL     = 4;
  localparam int unsigned NA     = 4;
  localparam int unsigned LW     = 2;

  logic              clk_i;
  logic              reset_i;
  logic              start_i;
  logic              frame_i;
  logic [AW-1:0]     step_addr_o;
  logic [NL-1:0]     step_data_i;
  logic [NA-1:0]     slot_done_i;
  logic [NA-1:0]     launch_o;
  logic [NA*LW-1:0]  slot_lane_o;
  logic [NA-1:0]     slot_busy_o;
  logic              busy_o;
  logic              done_o;
  logic [7:0]        drop_count_o;

  logic [NL-1:0] rom [0:127];

  int checks;
  int failures;

  arrow_launch_scheduler #(
    .FRAMES_PER_BEAT(FPB),
    .SONG_LEN(SLEN),
    .ADDR_W(AW),
    .LANES(NL),
    .ARROW_COUNT(NA)
  ) u_dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .start_i(start_i),
    .frame_i(frame_i),
    .step_addr_o(step_addr_o),
    .step_data_i(step_data_i),
    .slot_done_i(slot_done_i),
    .launch_o(launch_o),
    .slot_lane_o(slot_lane_o),
    .slot_busy_o(slot_busy_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .drop_count_o(drop_count_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Synchronous step ROM: data follows the address by one cycle.
  always @(posedge clk_i) step_data_i <= rom[step_addr_o];

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = '0;
  endtask

  task automatic cyc(input logic frm);
    frame_i = frm;
    @(posedge clk_i);
    #1;
    frame_i = 1'b0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  // One beat worth of frames, then wait for the step to retire; counts launches.
  task automatic run_step(input bit echo, output int n_launch);
    logic [AW-1:0] a;
    bit finished;
    a = step_addr_o;
    n_launch = 0;
    finished = 1'b0;
    for (int f = 0; f < int'(FPB); f++) cyc(1'b1);
    for (int i = 0; i < 20 && !finished; i++) begin
      @(posedge clk_i);
      #1;
      slot_done_i = '0;
      if (launch_o != '0) begin
        n_launch += $countones(launch_o);
        if (echo) slot_done_i = launch_o;
      end
      if (step_addr_o != a || done_o) finished = 1'b1;
    end
    slot_done_i = '0;
    checks++;
    if (!finished) begin
      failures++;
      $display("FAIL step_timeout: addr=%0d still pending, expected step to retire", a);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (step_addr_o !== '0) begin failures++; $display("FAIL rst_addr: got %0d expected 0", step_addr_o); end
    checks++; if (launch_o !== '0) begin failures++; $display("FAIL rst_launch: got %b expected 0000", launch_o); end
    checks++; if (slot_lane_o !== '0) begin failures++; $display("FAIL rst_lane: got %h expected 0", slot_lane_o); end
    checks++; if (slot_busy_o !== '0) begin failures++; $display("FAIL rst_slot_busy: got %b expected 0000", slot_busy_o); end
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin failures++; $display("FAIL rst_flags: got busy=%b done=%b expected 0 0", busy_o, done_o); end
    checks++; if (drop_count_o !== 8'd0) begin failures++; $display("FAIL rst_drop: got %0d expected 0", drop_count_o); end
  endtask

  task automatic test_basic_launch();
    int lat;
    bit got;
    clear_rom();
    rom[0] = 4'b0101;
    pulse_start();
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL start_busy: got %b expected 1", busy_o); end
    cyc(1'b1);
    cyc(1'b1);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk_i);
      #1;
      lat++;
      if (launch_o != '0) got = 1'b1;
    end
    checks++; if (!got || lat != 3) begin failures++; $display("FAIL first_latency: got %0d cycles (seen=%b) expected 3", lat, got); end
    checks++; if (launch_o !== 4'b0001) begin failures++; $display("FAIL launch_lane0: got %b expected 0001", launch_o); end
    checks++; if (slot_lane_o[1:0] !== 2'd0) begin failures++; $display("FAIL lane_slot0: got %0d expected 0", slot_lane_o[1:0]); end
    cyc(1'b0);
    checks++; if (launch_o !== 4'b0010) begin failures++; $display("FAIL launch_lane2: got %b expected 0010", launch_o); end
    checks++; if (slot_lane_o[3:2] !== 2'd2) begin failures++; $display("FAIL lane_slot1: got %0d expected 2", slot_lane_o[3:2]); end
    checks++; if (slot_busy_o !== 4'b0011) begin failures++; $display("FAIL busy_after_two: got %b expected 0011", slot_busy_o); end
    cyc(1'b0);
    checks++; if (launch_o !== 4'b0000) begin failures++; $display("FAIL launch_end: got %b expected 0000", launch_o); end
    do_reset();
  endtask

  task automatic test_drops_all_busy();
    int n;
    clear_rom();
    rom[0] = 4'b1111;
    rom[1] = 4'b1111;
    rom[2] = 4'b1000;
    pulse_start();
    run_step(1'b0, n);
    checks++; if (n != 4 || slot_busy_o !== 4'b1111) begin failures++; $display("FAIL fill_slots: got launches=%0d busy=%b expected 4 1111", n, slot_busy_o); end
    run_step(1'b0, n);
    checks++; if (n != 0) begin failures++; $display("FAIL drop_no_launch: got %0d launches expected 0", n); end
    checks++; if (drop_count_o !== 8'd4) begin failures++; $display("FAIL drop_count4: got %0d expected 4", drop_count_o); end
    checks++; if (step_addr_o !== AW'(2)) begin failures++; $display("FAIL drop_addr: got %0d expected 2", step_addr_o); end
  endtask

  task automatic test_release_same_cycle();
    int n;
    slot_done_i = 4'b1100;
    cyc(1'b0);
    slot_done_i = '0;
    checks++; if (slot_busy_o !== 4'b0011) begin failures++; $display("FAIL release_23: got %b expected 0011", slot_busy_o); end
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    slot_done_i = 4'b0001;
    cyc(1'b0);
    slot_done_i = '0;
    checks++; if (launch_o !== 4'b0100) begin failures++; $display("FAIL same_cycle_launch: got %b expected 0100", launch_o); end
    checks++; if (slot_lane_o[5:4] !== 2'd3) begin failures++; $display("FAIL same_cycle_lane: got %0d expected 3", slot_lane_o[5:4]); end
    checks++; if (slot_busy_o !== 4'b0110) begin failures++; $display("FAIL same_cycle_busy: got %b expected 0110", slot_busy_o); end
    cyc(1'b0);
    checks++; if (step_addr_o !== AW'(3)) begin failures++; $display("FAIL addr_after_release: got %0d expected 3", step_addr_o); end
    for (int s = 3; s < int'(SLEN); s++) run_step(1'b0, n);
`ifndef LOOP_SONG_EN
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("FAIL song_end_flags: got done=%b busy=%b expected 1 0", done_o, busy_o); end
    checks++; if (step_addr_o !== AW'(SLEN - 1) || drop_count_o !== 8'd4) begin failures++; $display("FAIL song_end_state: got addr=%0d drop=%0d expected %0d 4", step_addr_o, drop_count_o, SLEN - 1); end
    pulse_start();
    checks++; if (step_addr_o !== '0 || drop_count_o !== 8'd0) begin failures++; $display("FAIL restart_clear: got addr=%0d drop=%0d expected 0 0", step_addr_o, drop_count_o); end
    checks++; if (busy_o !== 1'b1 || done_o !== 1'b0 || slot_busy_o !== 4'b0110) begin failures++; $display("FAIL restart_state: got busy=%b done=%b slots=%b expected 1 0 0110", busy_o, done_o, slot_busy_o); end
`endif
  endtask

  task automatic test_song_done();
    int n;
    int total;
    do_reset();
    clear_rom();
    for (int i = 0; i < int'(SLEN); i++) rom[i] = 4'b0001;
    pulse_start();
    total = 0;
    for (int s = 0; s < int'(SLEN); s++) begin
      run_step(1'b1, n);
      total += n;
    end
    checks++; if (total != int'(SLEN)) begin failures++; $display("FAIL song_launches: got %0d expected %0d", total, SLEN); end
    checks++; if (slot_busy_o !== 4'b0000 || drop_count_o !== 8'd0) begin failures++; $display("FAIL song_echo: got slots=%b drop=%0d expected 0000 0", slot_busy_o, drop_count_o); end
`ifdef LOOP_SONG_EN
    checks++; if (done_o !== 1'b0 || busy_o !== 1'b1 || step_addr_o !== '0) begin failures++; $display("FAIL loop_wrap: got done=%b busy=%b addr=%0d expected 0 1 0", done_o, busy_o, step_addr_o); end
`else
    checks++; if (done_o !== 1'b1 || busy_o !== 1'b0 || step_addr_o !== AW'(SLEN - 1)) begin failures++; $display("FAIL song_done: got done=%b busy=%b addr=%0d expected 1 0 %0d", done_o, busy_o, step_addr_o, SLEN - 1); end
`endif
  endtask

  task automatic test_reset_mid_issue();
    int seen;
    do_reset();
    clear_rom();
    rom[0] = 4'b1111;
    pulse_start();
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b0);
    checks++; if (launch_o !== 4'b0001) begin failures++; $display("FAIL pre_reset_launch: got %b expected 0001", launch_o); end
    reset_i = 1'b1;
    cyc(1'b0);
    reset_i = 1'b0;
    checks++; if (launch_o !== '0 || slot_busy_o !== '0) begin failures++; $display("FAIL mid_reset_slots: got launch=%b busy=%b expected 0000 0000", launch_o, slot_busy_o); end
    checks++; if (busy_o !== 1'b0 || drop_count_o !== 8'd0 || step_addr_o !== '0) begin failures++; $display("FAIL mid_reset_state: got busy=%b drop=%0d addr=%0d expected 0 0 0", busy_o, drop_count_o, step_addr_o); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1);
      if (launch_o != '0) seen++;
    end
    checks++; if (seen != 0 || slot_busy_o !== '0) begin failures++; $display("FAIL post_reset_quiet: got %0d launch cycles busy=%b expected 0 0000", seen, slot_busy_o); end
  endtask

  task automatic test_drop_saturation();
    int n;
    clear_rom();
    for (int i = 0; i < int'(SLEN); i++) rom[i] = 4'b1111;
    pulse_start();
    for (int s = 0; s < int'(SLEN); s++) begin
      run_step(1'b0, n);
      if (s == 0) begin
        checks++; if (n != 4) begin failures++; $display("FAIL sat_fill: got %0d launches expected 4", n); end
      end
      if (s == 63) begin
        checks++; if (drop_count_o !== 8'd252) begin failures++; $display("FAIL sat_pre: got %0d expected 252", drop_count_o); end
      end
    end
    checks++; if (drop_count_o !== 8'd255) begin failures++; $display("FAIL sat_hold: got %0d expected 255", drop_count_o); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_i     = 1'b1;
    start_i     = 1'b0;
    frame_i     = 1'b0;
    slot_done_i = '0;
    clear_rom();
    test_reset();
    test_basic_launch();
    test_drops_all_busy();
    test_release_same_cycle();
    test_song_done();
    test_reset_mid_issue();
    test_drop_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
